// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache request arbiter and its round-robin picker:
// controller state encodings and default widths.
package cache_arb_pkg;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit after ptr
// (modulo N) wins. Also used by the refill/write-back arbiter.
module rr_pick #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      // k runs 1..N so the last winner (ptr itself) is considered last.
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!gnt_any && req[cand]) begin
            gnt_any       = 1'b1;
            gnt_oh[cand]  = 1'b1;
            gnt_idx       = cand;
         end
      end
   end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache port between NUM_REQ requesters, one
// outstanding transaction, with a watchdog that turns a stalled cache into an error response.
module cache_req_arbiter
   import cache_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic                      resp_err,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      cache_req_valid,
   input  logic                      cache_req_ready,
   output logic                      cache_we,
   output logic [ADDR_W-1:0]         cache_addr,
   output logic [DATA_W-1:0]         cache_wdata,
   input  logic                      cache_resp_valid,
   input  logic [DATA_W-1:0]         cache_resp_rdata,
   output logic                      busy
);

   // Handshake: a requester's transaction is taken in the cycle where its
   // req_valid and req_ready are both high; the cache takes the registered
   // request when cache_req_valid and cache_req_ready are both high.

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

   logic [NUM_REQ-1:0]  pick_oh;
   logic [IW-1:0]       pick_idx;
   logic                pick_any;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      resp_valid_d = '0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d  = pick_idx;
               rr_ptr_d = pick_idx;
               we_d     = req_we[pick_idx];
               addr_d   = sel_addr;
               wdata_d  = sel_wdata;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            // No watchdog here: a slow-accepting cache is backpressure, not a hang.
            if (cache_req_ready) begin
               cnt_d   = '0;
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // A real response beats expiry in the same cycle.
            if (cache_resp_valid) begin
               resp_valid_d[grant_q] = 1'b1;
               resp_rdata_d          = cache_resp_rdata;
               state_d               = IDLE;
            end else if (cnt_q >= CNT_LAST) begin
               resp_valid_d[grant_q] = 1'b1;
               resp_err_d            = 1'b1;
               resp_rdata_d          = '0;
               state_d               = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= IW'(NUM_REQ - 1);
         grant_q      <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         resp_valid_q <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Gated by rst so every output reads zero while reset is held.
   assign req_ready       = (state_q == IDLE && !rst) ? pick_oh : '0;
   assign cache_req_valid = (state_q == ISSUE);
   assign cache_we        = we_q;
   assign cache_addr      = addr_q;
   assign cache_wdata     = wdata_q;
   assign resp_valid      = resp_valid_q;
   assign resp_err        = resp_err_q;
   assign resp_rdata      = resp_rdata_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: a transaction-level reference model checked
// every cycle, plus literal latency/ordering expectations per scenario.
module tb_cache_req_arbiter;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic                clk, rst;
   logic [NR-1:0]       req_valid, req_ready, req_we, resp_valid;
   logic [NR*AW-1:0]    req_addr;
   logic [NR*DW-1:0]    req_wdata;
   logic                resp_err;
   logic [DW-1:0]       resp_rdata;
   logic                cache_req_valid, cache_req_ready, cache_we;
   logic [AW-1:0]       cache_addr;
   logic [DW-1:0]       cache_wdata, cache_resp_rdata;
   logic                cache_resp_valid, busy;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;
   typedef struct {
      int            idx;
      logic          err;
      logic [DW-1:0] data;
      int            cyc;
   } resp_t;
   typedef struct {
      int idx;
      int cyc;
   } gnt_t;

   txn_t  rq0[$], rq1[$];
   resp_t resp_log[$];
   gnt_t  gnt_log[$];
   int    issue_start_log[$];
   int    issue_len_log[$];

   int n_tests, n_fail, cyc;

   // cache-side stimulus knobs
   int            stall_left, resp_lat, pend;
   bit            no_resp;
   logic [DW-1:0] resp_data;

   // reference model state
   int            m_owner, m_rr, m_deadline, m_to;
   bit            m_issued, m_pend;
   logic          m_err, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_hold;
   int            crv_run;

   cache_req_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_err         (resp_err),
      .resp_rdata       (resp_rdata),
      .cache_req_valid  (cache_req_valid),
      .cache_req_ready  (cache_req_ready),
      .cache_we         (cache_we),
      .cache_addr       (cache_addr),
      .cache_wdata      (cache_wdata),
      .cache_resp_valid (cache_resp_valid),
      .cache_resp_rdata (cache_resp_rdata),
      .busy             (busy)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic int m_winner(input logic [NR-1:0] v, input int last);
      for (int k = 1; k <= NR; k++)
         if (v[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   // ---------------- driver ----------------
   task automatic present();
      req_valid[0] = (rq0.size() > 0);
      req_valid[1] = (rq1.size() > 0);
      req_we = '0; req_addr = '0; req_wdata = '0;
      if (rq0.size() > 0) begin
         req_we[0] = rq0[0].we; req_addr[0 +: AW] = rq0[0].addr; req_wdata[0 +: DW] = rq0[0].wdata;
      end
      if (rq1.size() > 0) begin
         req_we[1] = rq1[0].we; req_addr[AW +: AW] = rq1[0].addr; req_wdata[DW +: DW] = rq1[0].wdata;
      end
   endtask

   // One clock: sample handshakes at negedge, update inputs 1ns after posedge.
   task automatic tick();
      logic [NR-1:0] acc;
      logic          cacc;
      @(negedge clk);
      acc  = req_valid & req_ready;
      cacc = cache_req_valid & cache_req_ready;
      if (cache_req_valid && !cache_req_ready && stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
      if (acc[0]) rq0.delete(0);
      if (acc[1]) rq1.delete(0);
      present();
      cache_req_ready  = (stall_left == 0);
      cache_resp_valid = 1'b0;
      if (cacc && !no_resp) pend = resp_lat;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            cache_resp_valid = 1'b1;
            cache_resp_rdata = resp_data;
         end
      end
   endtask

   task automatic wait_resp(input int n, input int budget, input string name);
      int b;
      b = 0;
      while (resp_log.size() < n && b < budget) begin
         tick();
         b++;
      end
      chk(name, 64'(resp_log.size() >= n), 64'd1);
   endtask

   // ---------------- model + compare ----------------
   always @(negedge clk) begin
      logic [NR-1:0] exp_rdy, exp_rv;
      int            w;
      resp_t         r;
      gnt_t          g;
      cyc++;
      if (rst) begin
         m_owner = -1; m_rr = NR - 1; m_issued = 0; m_pend = 0; m_hold = '0;
         crv_run = 0;
         chk("rst_req_ready",  64'(req_ready), 64'd0);
         chk("rst_busy",       64'(busy), 64'd0);
         chk("rst_cache_req",  64'(cache_req_valid), 64'd0);
         chk("rst_cache_we",   64'(cache_we), 64'd0);
         chk("rst_cache_addr", 64'(cache_addr), 64'd0);
         chk("rst_cache_wd",   64'(cache_wdata), 64'd0);
         chk("rst_resp_valid", 64'(resp_valid), 64'd0);
         chk("rst_resp_err",   64'(resp_err), 64'd0);
         chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      end else begin
         w = (m_owner < 0) ? m_winner(req_valid, m_rr) : -1;
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         exp_rv = '0;
         if (m_pend) exp_rv[m_to] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(m_owner >= 0));
         chk("cache_req_valid", 64'(cache_req_valid), 64'(m_owner >= 0 && !m_issued));
         if (m_owner >= 0 && !m_issued) begin
            chk("cache_we",    64'(cache_we), 64'(m_we));
            chk("cache_addr",  64'(cache_addr), 64'(m_addr));
            chk("cache_wdata", 64'(cache_wdata), 64'(m_wdata));
         end
         chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
         chk("resp_err", 64'(resp_err), 64'(m_pend ? m_err : 1'b0));
         chk("resp_rdata", 64'(resp_rdata), 64'(m_hold));

         if (resp_valid != '0) begin
            r.idx = resp_valid[1] ? 1 : 0; r.err = resp_err; r.data = resp_rdata; r.cyc = cyc;
            resp_log.push_back(r);
         end
         if (req_ready != '0) begin
            g.idx = req_ready[1] ? 1 : 0; g.cyc = cyc;
            gnt_log.push_back(g);
         end
         if (cache_req_valid) begin
            if (crv_run == 0) issue_start_log.push_back(cyc);
            crv_run++;
         end else if (crv_run > 0) begin
            issue_len_log.push_back(crv_run);
            crv_run = 0;
         end

         // advance the model across the coming clock edge
         m_pend = 0;
         if (m_owner < 0) begin
            if (w >= 0) begin
               m_owner = w; m_rr = w; m_issued = 0;
               m_we = req_we[w]; m_addr = req_addr[w*AW +: AW]; m_wdata = req_wdata[w*DW +: DW];
            end
         end else if (!m_issued) begin
            if (cache_req_ready) begin
               m_issued   = 1;
               m_deadline = cyc + TO;  // last cycle of the TO-cycle response window
            end
         end else if (cache_resp_valid) begin
            m_pend = 1; m_to = m_owner; m_err = 1'b0; m_hold = cache_resp_rdata; m_owner = -1;
         end else if (cyc == m_deadline) begin
            m_pend = 1; m_to = m_owner; m_err = 1'b1; m_hold = '0; m_owner = -1;
         end
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int g0, r0, s0, i0;
      n_tests = 0; n_fail = 0; cyc = 0;
      rst = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      cache_req_ready = 1'b1; cache_resp_valid = 1'b0; cache_resp_rdata = '0;
      stall_left = 0; resp_lat = 1; pend = 0; no_resp = 0; resp_data = '0;
      #2 rst = 1'b1;
      tick(); tick();
      #2 rst = 1'b0;
      tick();

      // single read
      resp_data = 32'hFFFF_FFFF;
      g0 = gnt_log.size(); r0 = resp_log.size(); s0 = issue_start_log.size();
      rq0.push_back(mk(1'b0, 32'h0000_0000, 32'h0));
      present();
      wait_resp(r0 + 1, 20, "t1_wait_resp");
      if (resp_log.size() > r0 && gnt_log.size() > g0 && issue_start_log.size() > s0) begin
         chk("t1_grant_idx", 64'(gnt_log[g0].idx), 64'd0);
         chk("t1_issue_lat", 64'(issue_start_log[s0] - gnt_log[g0].cyc), 64'd1);
         chk("t1_resp_lat",  64'(resp_log[r0].cyc - gnt_log[g0].cyc), 64'd3);
         chk("t1_resp_idx",  64'(resp_log[r0].idx), 64'd0);
         chk("t1_resp_err",  64'(resp_log[r0].err), 64'd0);
         chk("t1_resp_data", 64'(resp_log[r0].data), 64'hFFFF_FFFF);
      end
      tick(); tick();

      // contention from a fresh reset
      #2 rst = 1'b1;
      tick(); tick();
      #2 rst = 1'b0;
      resp_data = 32'h1357_9BDF;
      g0 = gnt_log.size(); r0 = resp_log.size();
      rq0.push_back(mk(1'b1, 32'h0001_0000, 32'hAAAA_AAAA));
      rq0.push_back(mk(1'b1, 32'h0001_0000, 32'hAAAA_AAAA));
      rq1.push_back(mk(1'b0, 32'h0002_0000, 32'h0));
      rq1.push_back(mk(1'b0, 32'h0002_0000, 32'h0));
      present();
      wait_resp(r0 + 4, 60, "t2_wait_resp");
      if (resp_log.size() >= r0 + 4 && gnt_log.size() >= g0 + 4) begin
         for (int k = 0; k < 4; k++) begin
            chk("t2_grant_idx", 64'(gnt_log[g0+k].idx), 64'(k % 2));
            chk("t2_resp_idx",  64'(resp_log[r0+k].idx), 64'(k % 2));
         end
         for (int k = 0; k < 3; k++)
            chk("t2_grant_spacing", 64'(gnt_log[g0+k+1].cyc - gnt_log[g0+k].cyc), 64'd3);
         chk("t2_read_data", 64'(resp_log[r0+1].data), 64'h1357_9BDF);
      end
      tick(); tick();

      // backpressure: five stalled ISSUE cycles
      stall_left = 5; cache_req_ready = 1'b0;
      g0 = gnt_log.size(); r0 = resp_log.size(); i0 = issue_len_log.size();
      rq0.push_back(mk(1'b1, 32'h0000_0040, 32'hDEAD_BEEF));
      rq1.push_back(mk(1'b0, 32'h0000_0080, 32'h0));
      present();
      wait_resp(r0 + 2, 60, "t3_wait_resp");
      tick();
      if (resp_log.size() >= r0 + 2 && gnt_log.size() >= g0 + 2 && issue_len_log.size() > i0) begin
         chk("t3_issue_cycles", 64'(issue_len_log[i0]), 64'd6);
         chk("t3_first_grant",  64'(gnt_log[g0].idx), 64'd0);
         chk("t3_second_grant", 64'(gnt_log[g0+1].idx), 64'd1);
         chk("t3_grant_after_resp", 64'(gnt_log[g0+1].cyc - resp_log[r0].cyc), 64'd0);
         chk("t3_resp_lat", 64'(resp_log[r0].cyc - gnt_log[g0].cyc), 64'd8);
      end
      tick();

      // timeout: cache never answers
      no_resp = 1;
      g0 = gnt_log.size(); r0 = resp_log.size();
      rq1.push_back(mk(1'b0, 32'h0000_0100, 32'h0));
      present();
      wait_resp(r0 + 1, 40, "t4_wait_resp");
      if (resp_log.size() > r0 && gnt_log.size() > g0) begin
         chk("t4_resp_idx",  64'(resp_log[r0].idx), 64'd1);
         chk("t4_resp_err",  64'(resp_log[r0].err), 64'd1);
         chk("t4_resp_data", 64'(resp_log[r0].data), 64'd0);
         chk("t4_resp_lat",  64'(resp_log[r0].cyc - gnt_log[g0].cyc), 64'(2 + TO));
      end
      no_resp = 0;
      tick(); tick();

      // response lands on the last watchdog cycle
      resp_lat = TO; resp_data = 32'h5555_AAAA;
      g0 = gnt_log.size(); r0 = resp_log.size();
      rq0.push_back(mk(1'b0, 32'h0000_0200, 32'h0));
      present();
      wait_resp(r0 + 1, 40, "t5a_wait_resp");
      if (resp_log.size() > r0 && gnt_log.size() > g0) begin
         chk("t5a_resp_err",  64'(resp_log[r0].err), 64'd0);
         chk("t5a_resp_data", 64'(resp_log[r0].data), 64'h5555_AAAA);
         chk("t5a_resp_lat",  64'(resp_log[r0].cyc - gnt_log[g0].cyc), 64'(2 + TO));
      end
      resp_lat = 1;
      tick(); tick();

      // stray cache response while idle
      r0 = resp_log.size();
      cache_resp_valid = 1'b1; cache_resp_rdata = 32'h0BAD_0BAD;
      tick(); tick(); tick();
      chk("t5b_no_resp", 64'(resp_log.size() - r0), 64'd0);
      chk("t5b_rdata_held", 64'(resp_rdata), 64'h5555_AAAA);

      // asynchronous reset while waiting for the cache
      no_resp = 1;
      rq0.push_back(mk(1'b0, 32'h0000_0300, 32'h0));
      rq1.push_back(mk(1'b0, 32'h0000_0400, 32'h0));
      present();
      tick(); tick(); tick();
      chk("t6_busy_before", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_busy",       64'(busy), 64'd0);
      chk("t6_req_ready",  64'(req_ready), 64'd0);
      chk("t6_cache_req",  64'(cache_req_valid), 64'd0);
      chk("t6_cache_addr", 64'(cache_addr), 64'd0);
      chk("t6_resp_valid", 64'(resp_valid), 64'd0);
      chk("t6_resp_rdata", 64'(resp_rdata), 64'd0);
      pend = 0;
      if (rq0.size() == 0) rq0.push_back(mk(1'b0, 32'h0000_0500, 32'h0));
      if (rq1.size() == 0) rq1.push_back(mk(1'b0, 32'h0000_0600, 32'h0));
      tick(); tick();
      no_resp = 0; resp_lat = 1; resp_data = 32'h0F0F_0F0F;
      g0 = gnt_log.size(); r0 = resp_log.size();
      #2 rst = 1'b0;
      wait_resp(r0 + 2, 40, "t6_wait_resp");
      if (resp_log.size() >= r0 + 2 && gnt_log.size() > g0) begin
         chk("t6_first_grant", 64'(gnt_log[g0].idx), 64'd0);
         chk("t6_first_resp",  64'(resp_log[r0].idx), 64'd0);
         chk("t6_resp_lat",    64'(resp_log[r0].cyc - gnt_log[g0].cyc), 64'd3);
         chk("t6_second_resp", 64'(resp_log[r0+1].idx), 64'd1);
      end
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
